// File: rtl/restoring_divider.sv
// Iterative unsigned shift-and-subtract divider: one quotient bit per clock,
// start/busy/done handshake, results held until the next accepted start.
module restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_dbz
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dvd, dvd_nxt;
    logic [WIDTH-1:0] dvs, dvs_nxt;
    logic [WIDTH-1:0] prem, prem_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] quo, quo_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic             dbz, dbz_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;

    // Partial remainder is always below the divisor, so WIDTH bits hold it;
    // the extra bit only exists transiently in the shifted/trial values.
    always_comb begin
        state_nxt = state;
        dvd_nxt   = dvd;
        dvs_nxt   = dvs;
        prem_nxt  = prem;
        cnt_nxt   = cnt;
        quo_nxt   = quo;
        rem_nxt   = rem;
        dbz_nxt   = dbz;

        shifted = {prem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        qbit    = ~trial[WIDTH];

        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_divisor != '0) begin
                        dvd_nxt   = i_dividend;
                        dvs_nxt   = i_divisor;
                        prem_nxt  = '0;
                        cnt_nxt   = CW'(WIDTH - 1);
                        state_nxt = CALC;
                    end else begin
                        quo_nxt   = '1;
                        rem_nxt   = i_dividend;
                        dbz_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            CALC: begin
                prem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                dvd_nxt  = {dvd[WIDTH-2:0], qbit};
                if (cnt == '0) begin
                    quo_nxt   = dvd_nxt;
                    rem_nxt   = prem_nxt;
                    dbz_nxt   = 1'b0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            dvd   <= '0;
            dvs   <= '0;
            prem  <= '0;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            dvd   <= dvd_nxt;
            dvs   <= dvs_nxt;
            prem  <= prem_nxt;
            cnt   <= cnt_nxt;
            quo   <= quo_nxt;
            rem   <= rem_nxt;
            dbz   <= dbz_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    assign o_busy      = busy;
    assign o_done      = done;
    assign o_quotient  = quo;
    assign o_remainder = rem;
    assign o_dbz       = dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: vector table, corner sequences and a random
// sweep, all results checked by a scoreboard when o_done pulses.
module tb_restoring_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    restoring_divider #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_busy     (busy),
        .o_done     (done),
        .o_quotient (quotient),
        .o_remainder(remainder),
        .o_dbz      (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t exp_q[$];
    int   acc_q[$];
    int   done_log[$];
    vec_t tbl[8];

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;
    int busy_run = 0;

    logic [W-1:0] prev_q    = '0;
    logic [W-1:0] prev_r    = '0;
    logic         prev_dbz  = 1'b0;
    logic         prev_done = 1'b0;
    logic         prev_rst  = 1'b0;

    vec_t e_chk;
    int   a_chk;
    int   lat;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        v.dvd = a;
        v.dvs = b;
        if (b == '0) begin
            v.q   = '1;
            v.r   = a;
            v.dbz = 1'b1;
        end else begin
            v.q   = a / b;
            v.r   = a % b;
            v.dbz = 1'b0;
        end
        return v;
    endfunction

    // Scoreboard: note accepts, compare results and timing on every done pulse.
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            busy_run = 0;
            prev_rst = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (start && !busy) acc_q.push_back(ncyc);
            busy_run = busy ? busy_run + 1 : 0;
            if (prev_rst && !done) begin
                check("hold_quotient", quotient, prev_q);
                check("hold_remainder", remainder, prev_r);
                check("hold_dbz", dbz, prev_dbz);
            end
            if (done) begin
                check("done_single_cycle", prev_done, 0);
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no pending operation (t=%0t)", $time);
                end else begin
                    e_chk = exp_q.pop_front();
                    a_chk = acc_q.pop_front();
                    lat   = (e_chk.dvs == '0) ? 1 : W + 1;
                    check("quotient", quotient, e_chk.q);
                    check("remainder", remainder, e_chk.r);
                    check("dbz", dbz, e_chk.dbz);
                    check("done_latency", ncyc - a_chk, lat);
                    check("busy_cycles", busy_run, lat);
                    if (e_chk.dvs != '0) begin
                        check("invariant_sum", longint'(quotient) * e_chk.dvs + remainder, e_chk.dvd);
                        check("invariant_rem_lt_dvs", (remainder < e_chk.dvs) ? 1 : 0, 1);
                    end
                end
                done_log.push_back(ncyc);
            end
            prev_rst = 1'b1;
        end
        prev_q    = quotient;
        prev_r    = remainder;
        prev_dbz  = dbz;
        prev_done = done;
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout: got busy=1, expected busy=0 within 100 cycles");
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input vec_t e);
        wait_idle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    initial begin
        int n;
        int k;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        tbl[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        tbl[4] = '{8'h5A,  8'd0,   8'hFF,  8'h5A,  1'b1};
        tbl[5] = '{8'd20,  8'd3,   8'd6,   8'd2,   1'b0};
        tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        tbl[7] = '{8'd200, 8'd3,   8'd66,  8'd2,   1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", dbz, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].dvd, tbl[i].dvs, tbl[i]);
        end
        drain();

        // Start held high through CALC/DONE with new operands: taken on first IDLE cycle.
        wait_idle();
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        exp_q.push_back('{8'd200, 8'd3, 8'd66, 8'd2, 1'b0});
        @(posedge clk);
        #1;
        dividend = 8'd50;
        divisor  = 8'd7;
        exp_q.push_back('{8'd50, 8'd7, 8'd7, 8'd1, 1'b0});
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        n = done_log.size();
        check("held_start_gap", (n >= 2) ? done_log[n-1] - done_log[n-2] : -1, W + 2);

        // Reset in the middle of CALC abandons the operation.
        do_op(8'd200, 8'd3, '{8'd200, 8'd3, 8'd66, 8'd2, 1'b0});
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_quotient", quotient, 0);
        check("midreset_remainder", remainder, 0);
        check("midreset_dbz", dbz, 0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle_busy", busy, 0);
        check("post_reset_quotient", quotient, 0);
        do_op(8'd9, 8'd4, '{8'd9, 8'd4, 8'd2, 8'd1, 1'b0});
        drain();

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            do_op(ra, rb, model(ra, rb));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
